// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates branch conditions one cycle after a request,
// trains a 2-bit bimodal predictor table and counts mispredicts.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            predict_taken,
    input  logic            in_valid,
    input  logic [2:0]      inst_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            in_pred_taken,
    output logic            out_valid,
    output logic            take_branch,
    output logic            mispredict,
    output logic            illegal,
    output logic [15:0]     mispredict_count
);

    localparam int IDX = $clog2(BHT_DEPTH);

    logic [1:0]     bht [BHT_DEPTH];
    logic [IDX-1:0] lookup_idx;
    logic [IDX-1:0] update_idx;
    logic           cond_taken;
    logic           cond_legal;
    logic           cond_mispredict;
    logic           rs_eq;
    logic           rs_lt;
    logic           rs_ltu;

    // PC bits outside the index field are intentionally ignored, so tables alias
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[XLEN-1:IDX+2], lookup_pc[1:0],
                              in_pc[XLEN-1:IDX+2], in_pc[1:0]};

    assign lookup_idx    = lookup_pc[IDX+1:2];
    assign update_idx    = in_pc[IDX+1:2];
    assign predict_taken = bht[lookup_idx][1];

    assign rs_eq  = (rs1_data == rs2_data);
    assign rs_lt  = ($signed(rs1_data) < $signed(rs2_data));
    assign rs_ltu = (rs1_data < rs2_data);

    always_comb begin
        cond_taken = 1'b0;
        cond_legal = 1'b1;
        case (inst_funct3)
            3'b000:  cond_taken = rs_eq;
            3'b001:  cond_taken = !rs_eq;
            3'b100:  cond_taken = rs_lt;
            3'b101:  cond_taken = !rs_lt;
            3'b110:  cond_taken = rs_ltu;
            3'b111:  cond_taken = !rs_ltu;
            default: cond_legal = 1'b0;
        endcase
    end

    assign cond_mispredict = cond_legal && (cond_taken != in_pred_taken);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid        <= 1'b0;
            take_branch      <= 1'b0;
            mispredict       <= 1'b0;
            illegal          <= 1'b0;
            mispredict_count <= 16'd0;
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else begin
            out_valid   <= in_valid;
            take_branch <= in_valid && cond_taken;
            mispredict  <= in_valid && cond_mispredict;
            illegal     <= in_valid && !cond_legal;
            if (in_valid && cond_legal) begin
                // saturating 2-bit counter; lookup sees the pre-update value
                if (cond_taken && bht[update_idx] != 2'b11) begin
                    bht[update_idx] <= bht[update_idx] + 2'd1;
                end else if (!cond_taken && bht[update_idx] != 2'b00) begin
                    bht[update_idx] <= bht[update_idx] - 2'd1;
                end
                if (cond_mispredict && mispredict_count != 16'hFFFF) begin
                    mispredict_count <= mispredict_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and PC width in bits.
REQ-002 Parameter BHT_DEPTH, default 16, number of 2-bit predictor counters; SHALL be a power of two, at least 2.
REQ-003 Derived IDX = log2(BHT_DEPTH); table index = pc[IDX+1:2].
REQ-004 Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- lookup_pc  in  XLEN  fetch-side PC for prediction.
- predict_taken  out  1  combinational prediction for lookup_pc.
- in_valid  in  1  resolve request this cycle (branch instruction).
- inst_funct3  in  3  branch condition code.
- in_pc  in  XLEN  PC of the branch being resolved.
- rs1_data  in  XLEN  first operand.
- rs2_data  in  XLEN  second operand.
- in_pred_taken  in  1  prediction fetch used for this branch.
- out_valid  out  1  registered result valid.
- take_branch  out  1  registered resolved direction.
- mispredict  out  1  registered; take_branch != in_pred_taken.
- illegal  out  1  registered; funct3 was not a branch code.
- mispredict_count  out  16  running mispredict total.

Function
REQ-005 Conditions: 000 EQ rs1==rs2; 001 NE rs1!=rs2; 100 LT signed rs1<rs2; 101 GE signed rs1>=rs2; 110 LTU unsigned rs1<rs2; 111 GEU unsigned rs1>=rs2.
REQ-006 Signed compares SHALL use two's-complement at full XLEN width, with bit XLEN-1 as the sign bit.
REQ-007 funct3 010 or 011 is illegal; the unit SHALL compute take_branch=0, mispredict=0, illegal=1, and SHALL NOT update the table or the counter.
REQ-008 Latency: results SHALL appear exactly 1 cycle after the in_valid cycle; out_valid SHALL be high for 1 cycle per accepted request.
REQ-009 A request is accepted every cycle in_valid=1; there is no backpressure, and back-to-back requests SHALL produce back-to-back results.
REQ-010 When out_valid=0, take_branch, mispredict and illegal SHALL be 0.
REQ-011 Predictor: BHT_DEPTH 2-bit saturating counters; states 00 SN, 01 WN, 10 WT, 11 ST.
REQ-012 predict_taken SHALL equal bit 1 of the counter indexed by lookup_pc[IDX+1:2], combinationally, with no registered delay.
REQ-013 On a legal accepted request, the counter at in_pc[IDX+1:2] SHALL increment if taken and decrement if not taken.
REQ-014 Counter updates SHALL saturate: 11 stays 11 when taken; 00 stays 00 when not taken.
REQ-015 A lookup and an update to the same index in the same cycle SHALL return the pre-update value; no bypass.
REQ-016 mispredict_count SHALL increment by 1 for each legal accepted request with a mispredict.
REQ-017 mispredict_count SHALL saturate at 0xFFFF; no wrap.
REQ-018 in_pc bits [1:0] and bits above IDX+1 SHALL be ignored for indexing; aliasing is permitted.

Reset
REQ-019 Reset SHALL act immediately, without waiting for a clock edge.
REQ-020 While reset is high: out_valid=0, take_branch=0, mispredict=0, illegal=0, mispredict_count=0, every counter=01 (WN).
REQ-021 A request in the cycle reset deasserts SHALL be accepted normally.
REQ-022 Reset asserted while a result is pending SHALL discard it; no out_valid pulse SHALL follow.

Verification
REQ-023 After reset, lookup_pc=0x40 -> predict_taken=0. Request BEQ, in_pc=0x40, rs1=rs2=5, in_pred_taken=0 -> next cycle out_valid=1, take_branch=1, mispredict=1, count=1. Then predict_taken for 0x40 = 1.
REQ-024 BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken. BGE rs1=0x80000000, rs2=0 -> not taken.
REQ-025 Four taken BEQs at in_pc=0x10 -> counter 11. One not-taken -> 10; predict_taken stays 1.
REQ-026 funct3=010 with in_valid=1 -> illegal=1, take_branch=0, mispredict=0; counter and count unchanged.
REQ-027 BHT_DEPTH=16: in_pc=0x00 and in_pc=0x40 alias to index 0. Lookup and update of index 0 in the same cycle -> lookup shows the old value.
REQ-028 Reset pulse mid-stream with 0x10000 forced mispredicts -> count saturates at 0xFFFF; after reset, count=0, all counters WN, no stray out_valid.
